execute_ctrl: RTL and testbench

Sequencer for the execute stage register. Owns the decode→execute and execute→memory valid/ready handshakes and drives the register's write enable `exe_we_o`, which is wired to `we_i`. It holds the stage while multi-cycle operations (mul, div, load/store) complete. It also drops in-flight work on a pipeline flush and counts decode stall cycles.

---
 rtl/execute_ctrl_pkg.sv | 20 ++
 rtl/execute_ctrl_lat_cnt.sv | 31 +++
 rtl/execute_ctrl.sv | 128 ++++++++++++
 tb/tb_execute_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/execute_ctrl_pkg.sv
// execute_ctrl_pkg
//   Shared definitions for the execute-stage sequencer: op-class bus width,
//   op-class codes presented by decode, and the latency-counter width helper.
package execute_ctrl_pkg;

    localparam int EXE_CLASS_BUS = 2;

    typedef enum logic [EXE_CLASS_BUS-1:0] {
        EXE_CLASS_SINGLE = 2'd0,
        EXE_CLASS_MUL    = 2'd1,
        EXE_CLASS_DIV    = 2'd2,
        EXE_CLASS_LSU    = 2'd3
    } exe_class_e;

    // Counter must hold lat-1; never narrower than one bit.
    function automatic int lat_cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/execute_ctrl_lat_cnt.sv
// exe_lat_cnt
//   Loadable down-counter used to time multi-cycle execute ops.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     load, load_val : load the counter (takes priority over dec)
//     dec            : decrement by one, saturating at zero
//     cnt, zero      : current value and cnt==0 flag
module exe_lat_cnt #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/execute_ctrl.sv
// execute_ctrl
//   Sequencer for the execute stage register. Handles the decode->execute and
//   execute->memory handshakes, holds the stage for mul/div/lsu ops, drops
//   in-flight work on flush and counts decode stall cycles.
//   Ports:
//     clock, reset            : clock, synchronous active-high reset
//     id_valid_i, id_class_i  : instruction offered by decode and its op class
//     id_ready_o, exe_we_o    : execute accepts / loads its register (same cycle)
//     flush_i                 : redirect, kills held or incoming instruction
//     lsu_req_o, lsu_done_i   : memory access request level / completion pulse
//     ex_valid_o, ex_ready_i  : result handshake to the next stage
//     busy_o                  : stage occupied
//     stall_cnt_o             : cycles with decode valid but not accepted
module execute_ctrl
    import execute_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     id_valid_i,
    input  logic [EXE_CLASS_BUS-1:0] id_class_i,
    output logic                     id_ready_o,
    output logic                     exe_we_o,
    input  logic                     flush_i,
    output logic                     lsu_req_o,
    input  logic                     lsu_done_i,
    output logic                     ex_valid_o,
    input  logic                     ex_ready_i,
    output logic                     busy_o,
    output logic [31:0]              stall_cnt_o
);

    localparam int CW = lat_cnt_width(DIV_LAT);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_EXEC,
        S_LSU_WAIT,
        S_DONE
    } state_e;

    state_e      state;
    logic        drop;
    logic [31:0] stall_q;
    logic        accept;
    logic        cnt_zero;
    logic [CW-1:0] cnt;
    exe_class_e  cls;

    assign cls = exe_class_e'(id_class_i);

    // All handshake decisions are combinational so back-to-back single ops
    // sustain one per cycle; reset forces every output low.
    assign id_ready_o  = !reset && !flush_i &&
                         (state == S_EMPTY || (state == S_DONE && ex_ready_i));
    assign accept      = id_valid_i && id_ready_o;
    assign exe_we_o    = accept;
    assign ex_valid_o  = !reset && !flush_i && state == S_DONE;
    assign lsu_req_o   = !reset && state == S_LSU_WAIT;
    assign busy_o      = !reset && state != S_EMPTY;
    assign stall_cnt_o = reset ? 32'd0 : stall_q;

    function automatic state_e accept_state(input exe_class_e c);
        case (c)
            EXE_CLASS_SINGLE: return S_DONE;
            EXE_CLASS_LSU:    return S_LSU_WAIT;
            default:          return S_EXEC;
        endcase
    endfunction

    exe_lat_cnt #(.W(CW)) u_lat_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (accept && (cls == EXE_CLASS_MUL || cls == EXE_CLASS_DIV)),
        .load_val ((cls == EXE_CLASS_DIV) ? DIV_LOAD : MUL_LOAD),
        .dec      (state == S_EXEC),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_EMPTY;
            drop    <= 1'b0;
            stall_q <= '0;
        end else begin
            if (id_valid_i && !id_ready_o)
                stall_q <= stall_q + 32'd1;

            case (state)
                S_EMPTY: begin
                    if (accept)
                        state <= accept_state(cls);
                end
                S_EXEC: begin
                    if (flush_i)
                        state <= S_EMPTY;
                    else if (cnt_zero)
                        state <= S_DONE;
                end
                // The memory access is never abandoned: a flush only marks
                // the result for discard once the access completes.
                S_LSU_WAIT: begin
                    if (lsu_done_i) begin
                        state <= (drop || flush_i) ? S_EMPTY : S_DONE;
                        drop  <= 1'b0;
                    end else if (flush_i) begin
                        drop  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush_i)
                        state <= S_EMPTY;
                    else if (accept)
                        state <= accept_state(cls);
                    else if (ex_ready_i)
                        state <= S_EMPTY;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_ctrl.sv
module tb_execute_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid_i = 1'b0;
    logic [1:0]  id_class_i = 2'd0;
    logic        id_ready_o, exe_we_o;
    logic        flush_i = 1'b0;
    logic        lsu_req_o;
    logic        lsu_done_i = 1'b0;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b0;
    logic        busy_o;
    logic [31:0] stall_cnt_o;

    always #5 clock = ~clock;

    execute_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid_i  (id_valid_i),
        .id_class_i  (id_class_i),
        .id_ready_o  (id_ready_o),
        .exe_we_o    (exe_we_o),
        .flush_i     (flush_i),
        .lsu_req_o   (lsu_req_o),
        .lsu_done_i  (lsu_done_i),
        .ex_valid_o  (ex_valid_o),
        .ex_ready_i  (ex_ready_i),
        .busy_o      (busy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage holds at most one instruction, described by
    // the absolute cycle at which its result becomes visible, or by an
    // outstanding memory access (possibly already killed).
    int          mcyc = 0;
    bit          occ = 0, mem = 0, killed = 0;
    int          ready_at = 0;
    logic [31:0] m_stall = 0;

    // Outputs sampled in the last step, for the hand-written checks.
    logic        o_rdy, o_we, o_vld, o_req, o_busy;
    logic [31:0] o_stall;

    task automatic step(input logic rst, input logic v, input logic [1:0] cls,
                        input logic fl, input logic dn, input logic er);
        bit res_ok, e_rdy, e_vld;
        @(negedge clock);
        reset = rst; id_valid_i = v; id_class_i = cls;
        flush_i = fl; lsu_done_i = dn; ex_ready_i = er;
        #1;
        res_ok = occ && !mem && (mcyc >= ready_at);
        e_rdy  = !rst && !fl && (!occ || (res_ok && er));
        e_vld  = !rst && !fl && res_ok;
        o_rdy = id_ready_o; o_we = exe_we_o; o_vld = ex_valid_o;
        o_req = lsu_req_o; o_busy = busy_o; o_stall = stall_cnt_o;
        chk("id_ready", {31'd0, id_ready_o}, {31'd0, e_rdy});
        chk("exe_we", {31'd0, exe_we_o}, {31'd0, e_rdy && v});
        chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, e_vld});
        chk("lsu_req", {31'd0, lsu_req_o}, {31'd0, !rst && occ && mem});
        chk("busy", {31'd0, busy_o}, {31'd0, !rst && occ});
        chk("stall_cnt", stall_cnt_o, rst ? 32'd0 : m_stall);
        @(posedge clock);
        if (rst) begin
            occ = 0; mem = 0; killed = 0; m_stall = 0;
        end else begin
            if (v && !e_rdy) m_stall = m_stall + 32'd1;
            if (occ && mem) begin
                if (dn) begin
                    if (killed || fl) occ = 0;
                    else begin mem = 0; ready_at = mcyc + 1; end
                    killed = 0;
                end else if (fl) killed = 1;
            end else if (fl) begin
                occ = 0;
            end else if (v && e_rdy) begin
                occ = 1; mem = 0; killed = 0;
                case (cls)
                    2'd0: ready_at = mcyc + 1;
                    2'd1: ready_at = mcyc + 1 + MUL_LAT;
                    2'd2: ready_at = mcyc + 1 + DIV_LAT;
                    default: mem = 1;
                endcase
            end else if (res_ok && er) begin
                occ = 0;
            end
        end
        mcyc++;
    endtask

    typedef struct {
        logic v; logic [1:0] cls; logic er;
        logic rdy; logic we; logic vld; logic [31:0] stall;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [1:0] cls, input logic er,
                                input logic rdy, input logic we, input logic vld,
                                input int stall);
        vec_t r;
        r.v = v; r.cls = cls; r.er = er; r.rdy = rdy; r.we = we; r.vld = vld;
        r.stall = 32'(stall);
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        bit seen, reqok;

        // back-to-back singles, then a mul with decode held, then back-pressure
        tbl[0]  = mk(1, 0, 1, 1, 1, 0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 1, 1, 0);
        tbl[2]  = mk(1, 0, 1, 1, 1, 1, 0);
        tbl[3]  = mk(1, 0, 1, 1, 1, 1, 0);
        tbl[4]  = mk(0, 0, 1, 1, 0, 1, 0);
        tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1, 1, 1, 1, 0, 0);
        tbl[7]  = mk(1, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0, 0, 1);
        tbl[9]  = mk(1, 0, 1, 0, 0, 0, 2);
        tbl[10] = mk(1, 0, 1, 1, 1, 1, 3);
        for (int i = 11; i <= 15; i++) tbl[i] = mk(0, 0, 0, 0, 0, 1, 3);
        tbl[16] = mk(1, 0, 1, 1, 1, 1, 3);
        tbl[17] = mk(0, 0, 1, 1, 0, 1, 3);
        tbl[18] = mk(0, 0, 1, 1, 0, 0, 3);

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        chk("reset_ready", {31'd0, o_rdy}, 32'd0);
        chk("reset_stall", o_stall, 32'd0);

        foreach (tbl[i]) begin
            step(0, tbl[i].v, tbl[i].cls, 0, 0, tbl[i].er);
            chk($sformatf("tbl%0d_ready", i), {31'd0, o_rdy}, {31'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_we", i), {31'd0, o_we}, {31'd0, tbl[i].we});
            chk($sformatf("tbl%0d_valid", i), {31'd0, o_vld}, {31'd0, tbl[i].vld});
            chk($sformatf("tbl%0d_stall", i), o_stall, tbl[i].stall);
        end

        // LSU op flushed while waiting; access still completes, result dropped
        step(0, 1, 3, 0, 0, 1);
        chk("lsu_accept", {31'd0, o_we}, 32'd1);
        seen = 0; reqok = 1;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, i == 2, i == 6, 1);
            if (!o_req) reqok = 0;
            if (o_vld) seen = 1;
        end
        step(0, 0, 0, 0, 0, 1);
        if (o_vld) seen = 1;
        chk("lsu_req_held", {31'd0, reqok}, 32'd1);
        chk("lsu_no_valid", {31'd0, seen}, 32'd0);
        chk("lsu_empty", {31'd0, o_busy}, 32'd0);

        // div flushed at EXEC cycle 10; new op accepted the next cycle
        step(0, 1, 2, 0, 0, 1);
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, i == 10, 0, 1);
            if (o_vld) seen = 1;
        end
        step(0, 1, 0, 0, 0, 1);
        chk("div_flush_empty", {31'd0, o_busy}, 32'd0);
        chk("div_flush_accept", {31'd0, o_we}, 32'd1);
        chk("div_no_valid", {31'd0, seen}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("post_flush_valid", {31'd0, o_vld}, 32'd1);

        // reset mid-EXEC, then a stray lsu_done
        step(0, 1, 2, 0, 0, 1);
        repeat (4) step(0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1, 1);
        chk("rst_outs", {26'd0, o_rdy, o_we, o_vld, o_req, o_busy, 1'b0}, 32'd0);
        chk("rst_stall", o_stall, 32'd0);
        step(0, 0, 0, 0, 1, 1);
        chk("stray_busy", {31'd0, o_busy}, 32'd0);
        chk("stray_stall", o_stall, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("stray_idle", {30'd0, o_busy, o_vld}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 7,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
